// File: rtl/gera_pulso_borda.sv
// Push-button / IR line conditioner: synchroniser, debounce filter and rising-edge
// detector producing one registered single-cycle pulse per accepted press.
module gera_pulso_borda #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic                   b;
  logic                   s;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   d_q, d_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pulso_q, pulso_d;

  // Normalise so that downstream logic always sees a press as 1.
  assign b = ACTIVE_LOW ? ~button : button;
  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], b};
  end

  // cnt counts consecutive clocks of disagreement; any agreement restarts it,
  // so it can never exceed DEBOUNCE_CYCLES-1 and never wraps.
  always_comb begin
    d_d     = d_q;
    cnt_d   = cnt_q;
    pulso_d = 1'b0;
    if (s == d_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      d_d     = s;
      cnt_d   = '0;
      pulso_d = s;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      d_q     <= 1'b0;
      cnt_q   <= '0;
      pulso_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      pulso_q <= pulso_d;
    end
  end

  assign pulso = pulso_q;

endmodule

// File: tb/tb_gera_pulso_borda.sv
// Bench for gera_pulso_borda: directed press/bounce/reset scenarios plus randomized
// button activity against a sliding-window reference model, on both polarities.
module tb_gera_pulso_borda;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic button    = 1'b0;
  logic button_al = 1'b1;
  logic pulso;
  logic pulso_al;

  int checks = 0;
  int passes = 0;

  gera_pulso_borda #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .button(button), .pulso(pulso)
  );

  gera_pulso_borda #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .button(button_al), .pulso(pulso_al)
  );

  always #5 clk = ~clk;

  // Reference: s is the normalised button delayed by SYNC clocks; a new level is
  // accepted when the last DEB values of s all disagree with the accepted level.
  bit sh  [2][SYNC];
  bit win [2][DEB];
  bit md  [2];
  bit exp_p [2];

  always @(posedge clk or posedge rst) begin : ref_model
    bit s_now;
    bit all_diff;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < SYNC; j++) sh[i][j] = 1'b0;
        for (int j = 0; j < DEB; j++) win[i][j] = 1'b0;
        md[i]    = 1'b0;
        exp_p[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        s_now = sh[i][0];
        for (int j = 0; j < SYNC - 1; j++) sh[i][j] = sh[i][j+1];
        sh[i][SYNC-1] = (i == 0) ? button : ~button_al;
        for (int j = 0; j < DEB - 1; j++) win[i][j] = win[i][j+1];
        win[i][DEB-1] = s_now;
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) if (win[i][j] == md[i]) all_diff = 1'b0;
        exp_p[i] = 1'b0;
        if (all_diff) begin
          md[i]    = ~md[i];
          exp_p[i] = md[i];
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    button = 1'b0;
    button_al = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (pulso !== 1'b0 || dut.cnt_q !== '0)
      $display("FAIL reset_state: pulso=%b cnt=%0d required pulso=0 cnt=0", pulso, dut.cnt_q);
    else passes++;
    rst = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      checks++;
      if (pulso !== 1'b0 || pulso_al !== 1'b0)
        $display("FAIL reset_idle cyc %0d: pulso=%b pulso_al=%b required 0 0", i, pulso, pulso_al);
      else passes++;
    end
  endtask

  task automatic test_clean_press();
    for (int step = 0; step <= 20; step++) begin
      @(negedge clk);
      checks++;
      if (pulso !== (step == LAT))
        $display("FAIL clean_press step %0d: pulso=%b required %b", step, pulso, (step == LAT));
      else passes++;
      if (step == 0) button = 1'b1;
    end
    button = 1'b0;
    for (int step = 1; step <= 12; step++) begin
      @(negedge clk);
      checks++;
      if (pulso !== 1'b0)
        $display("FAIL clean_release step %0d: pulso=%b required 0", step, pulso);
      else passes++;
    end
  endtask

  task automatic test_bounce();
    for (int step = 0; step <= 20; step++) begin
      @(negedge clk);
      checks++;
      if (pulso !== (step == 4 + LAT))
        $display("FAIL bounce step %0d: pulso=%b required %b", step, pulso, (step == 4 + LAT));
      else passes++;
      if (step <= 4) button = (step % 2 == 0);
    end
    button = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit want;
    for (int step = 0; step <= 45; step++) begin
      @(negedge clk);
      want = (step == LAT) || (step == 20 + LAT);
      checks++;
      if (pulso !== want)
        $display("FAIL press_release_press step %0d: pulso=%b required %b", step, pulso, want);
      else passes++;
      if (step == 0)  button = 1'b1;
      if (step == 10) button = 1'b0;
      if (step == 20) button = 1'b1;
    end
    button = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_active_low();
    for (int step = 0; step <= 35; step++) begin
      @(negedge clk);
      checks++;
      if (pulso_al !== (step == LAT) || pulso !== 1'b0)
        $display("FAIL active_low step %0d: pulso_al=%b pulso=%b required %b 0",
                 step, pulso_al, pulso, (step == LAT));
      else passes++;
      if (step == 0)  button_al = 1'b0;
      if (step == 15) button_al = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    for (int step = 0; step <= 4; step++) begin
      @(negedge clk);
      if (step == 0) button = 1'b1;
    end
    checks++;
    if (dut.cnt_q !== 2)
      $display("FAIL pre_reset_count: cnt=%0d required 2", dut.cnt_q);
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dut.cnt_q !== '0 || pulso !== 1'b0)
      $display("FAIL async_rst_count: cnt=%0d pulso=%b required 0 0", dut.cnt_q, pulso);
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Button still held across reset: a fresh press must be accepted from scratch.
    for (int step = 1; step <= 15; step++) begin
      @(negedge clk);
      checks++;
      if (pulso !== (step == LAT))
        $display("FAIL held_through_rst step %0d: pulso=%b required %b", step, pulso, (step == LAT));
      else passes++;
    end
    button = 1'b0;
    repeat (12) @(negedge clk);
    button = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pulso === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL mid_pulse_wait: pulso never high within 20 cycles, required 1");
    else passes++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (pulso !== 1'b0)
      $display("FAIL async_rst_pulse: pulso=%b required 0", pulso);
    else passes++;
    @(negedge clk);
    button = 1'b0;
    rst = 1'b0;
    for (int step = 1; step <= 15; step++) begin
      @(negedge clk);
      checks++;
      if (pulso !== 1'b0)
        $display("FAIL post_rst_quiet step %0d: pulso=%b required 0", step, pulso);
      else passes++;
    end
  endtask

  task automatic test_random();
    int hold0 = 0;
    int hold1 = 0;
    int last0 = -1000;
    int last1 = -1000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checks++;
      if (pulso !== exp_p[0] || pulso_al !== exp_p[1])
        $display("FAIL random cyc %0d: pulso=%b pulso_al=%b required %b %b",
                 cyc, pulso, pulso_al, exp_p[0], exp_p[1]);
      else passes++;
      if (pulso === 1'b1) begin
        checks++;
        if (cyc - last0 < 2 * DEB)
          $display("FAIL spacing cyc %0d: gap=%0d required >= %0d", cyc, cyc - last0, 2 * DEB);
        else passes++;
        last0 = cyc;
      end
      if (pulso_al === 1'b1) begin
        checks++;
        if (cyc - last1 < 2 * DEB)
          $display("FAIL spacing_al cyc %0d: gap=%0d required >= %0d", cyc, cyc - last1, 2 * DEB);
        else passes++;
        last1 = cyc;
      end
      if (hold0 == 0) begin
        button = $urandom_range(0, 1);
        hold0 = $urandom_range(1, 12);
      end
      hold0--;
      if (hold1 == 0) begin
        button_al = $urandom_range(0, 1);
        hold1 = $urandom_range(1, 12);
      end
      hold1--;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_back_to_back();
    test_active_low();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
